// File: rtl/icache_pkg.sv
// Shared widths, bus command encoding and fill-FSM states for the fetch-side
// instruction cache. The cache array and its miss controller both use these.
package icache_pkg;

  localparam int OFF_BITS     = 3;
  localparam int IDX_BITS     = 5;
  localparam int TAG_BITS     = 8;
  localparam int MEM_TAG_BITS = 4;

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    BUS_LOAD = 2'd1
  } mem_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FILL = 2'd3
  } fill_state_t;

  function automatic logic [63:0] line_align(input logic [63:0] addr);
    return {addr[63:OFF_BITS], {OFF_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_fill_ctrl.sv
// Fetch-side miss controller: serves hits straight from the array read port and
// handles one outstanding miss at a time (LOAD, wait for tagged reply, fill).
//
// Handshakes: the LOAD is held on proc2Imem_command/addr every cycle in REQ
// until Imem2proc_response is nonzero in that same cycle; the nonzero value is
// the transaction tag, and the line is accepted when Imem2proc_tag equals it.
module icache_fill_ctrl
  import icache_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    fetch_req,
  input  logic [63:0]             fetch_addr,
  output logic [63:0]             fetch_data,
  output logic                    fetch_valid,
  output logic [IDX_BITS-1:0]     rd_idx,
  output logic [TAG_BITS-1:0]     rd_tag,
  input  logic [63:0]             cache_rd_data,
  input  logic                    cache_rd_valid,
  output logic                    wr_en,
  output logic [IDX_BITS-1:0]     wr_idx,
  output logic [TAG_BITS-1:0]     wr_tag,
  output logic [63:0]             wr_data,
  output logic [1:0]              proc2Imem_command,
  output logic [63:0]             proc2Imem_addr,
  input  logic [MEM_TAG_BITS-1:0] Imem2proc_response,
  input  logic [63:0]             Imem2proc_data,
  input  logic [MEM_TAG_BITS-1:0] Imem2proc_tag,
  output logic [1:0]              dbg_state
);

  fill_state_t             state_q, state_d;
  logic [MEM_TAG_BITS-1:0] pend_tag_q, pend_tag_d;
  logic [IDX_BITS-1:0]     idx_q, idx_d;
  logic [TAG_BITS-1:0]     tag_q, tag_d;
  logic [63:0]             addr_q, addr_d;
  logic [63:0]             data_q, data_d;
  logic                    wr_en_q;
  mem_cmd_t                cmd_q;

  logic unused_offset;
  assign unused_offset = ^fetch_addr[OFF_BITS-1:0];

  // Hit path is purely combinational and stays live in every FSM state.
  assign rd_idx      = fetch_addr[OFF_BITS +: IDX_BITS];
  assign rd_tag      = fetch_addr[OFF_BITS+IDX_BITS +: TAG_BITS];
  assign fetch_data  = cache_rd_data;
  assign fetch_valid = fetch_req & cache_rd_valid;

  always_comb begin
    state_d    = state_q;
    pend_tag_d = pend_tag_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    addr_d     = addr_q;
    data_d     = data_q;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req && !cache_rd_valid) begin
          idx_d   = rd_idx;
          tag_d   = rd_tag;
          addr_d  = line_align(fetch_addr);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (Imem2proc_response != '0) begin
          pend_tag_d = Imem2proc_response;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // pend_tag is nonzero here, so the idle tag value 0 can never match.
        if ((Imem2proc_tag == pend_tag_q) && (Imem2proc_tag != '0)) begin
          data_d  = Imem2proc_data;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pend_tag_q <= '0;
      idx_q      <= '0;
      tag_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_en_q    <= 1'b0;
      cmd_q      <= BUS_NONE;
    end else begin
      state_q    <= state_d;
      pend_tag_q <= pend_tag_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      // Decoded one cycle early so the bus and write ports come straight from flops.
      wr_en_q    <= (state_d == ST_FILL);
      cmd_q      <= (state_d == ST_REQ) ? BUS_LOAD : BUS_NONE;
    end
  end

  assign wr_en             = wr_en_q;
  assign wr_idx            = idx_q;
  assign wr_tag            = tag_q;
  assign wr_data           = data_q;
  assign proc2Imem_command = cmd_q;
  assign proc2Imem_addr    = addr_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl with a behavioural 32-line array model
// standing in for the parent's cache array.
module tb_icache_fill_ctrl;

  logic        clock;
  logic        reset;
  logic        fetch_req;
  logic [63:0] fetch_addr;
  logic [63:0] fetch_data;
  logic        fetch_valid;
  logic [4:0]  rd_idx;
  logic [7:0]  rd_tag;
  logic [63:0] cache_rd_data;
  logic        cache_rd_valid;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [7:0]  wr_tag;
  logic [63:0] wr_data;
  logic [1:0]  proc2Imem_command;
  logic [63:0] proc2Imem_addr;
  logic [3:0]  Imem2proc_response;
  logic [63:0] Imem2proc_data;
  logic [3:0]  Imem2proc_tag;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int wr_cnt   = 0;
  int load_cnt = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_FILL = 2'd3;
  localparam logic [1:0] C_NONE = 2'd0, C_LOAD = 2'd1;

  icache_fill_ctrl dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .rd_idx(rd_idx), .rd_tag(rd_tag),
    .cache_rd_data(cache_rd_data), .cache_rd_valid(cache_rd_valid),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag(wr_tag), .wr_data(wr_data),
    .proc2Imem_command(proc2Imem_command), .proc2Imem_addr(proc2Imem_addr),
    .Imem2proc_response(Imem2proc_response), .Imem2proc_data(Imem2proc_data),
    .Imem2proc_tag(Imem2proc_tag), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // array model: written by the DUT fill port or by bench preloads
  logic        m_valid [32];
  logic [7:0]  m_tag   [32];
  logic [63:0] m_data  [32];
  logic        pl_en, model_clr;
  logic [4:0]  pl_idx;
  logic [7:0]  pl_tag;
  logic [63:0] pl_data;

  always @(posedge clock) begin
    if (model_clr) begin
      for (int i = 0; i < 32; i++) begin
        m_valid[i] <= 1'b0;
        m_tag[i]   <= 8'h0;
        m_data[i]  <= 64'h0;
      end
    end else if (wr_en) begin
      m_valid[wr_idx] <= 1'b1;
      m_tag[wr_idx]   <= wr_tag;
      m_data[wr_idx]  <= wr_data;
    end else if (pl_en) begin
      m_valid[pl_idx] <= 1'b1;
      m_tag[pl_idx]   <= pl_tag;
      m_data[pl_idx]  <= pl_data;
    end
  end

  assign cache_rd_data  = m_data[rd_idx];
  assign cache_rd_valid = m_valid[rd_idx] && (m_tag[rd_idx] == rd_tag);

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
    if (wr_en) wr_cnt++;
    if (proc2Imem_command == C_LOAD) load_cnt++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] idx, input logic [7:0] tg, input logic [63:0] d);
    pl_en = 1'b1; pl_idx = idx; pl_tag = tg; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  typedef struct {
    logic        req;
    logic [63:0] addr;
    logic        exp_valid;
    logic [4:0]  exp_idx;
    logic [7:0]  exp_tag;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[6];
  int   w0, l0;

  initial begin
    vecs[0] = '{1'b1, 64'h0000_0000_0000_A528, 1'b1, 5'd5,  8'hA5, 64'h5555_5555_5555_5555};
    vecs[1] = '{1'b1, 64'h1234_0000_0000_FFF8, 1'b1, 5'd31, 8'hFF, 64'hFFFF_0000_FFFF_0000};
    vecs[2] = '{1'b0, 64'h0000_0000_0000_A52F, 1'b0, 5'd5,  8'hA5, 64'h5555_5555_5555_5555};
    vecs[3] = '{1'b0, 64'h0000_0000_0000_0007, 1'b0, 5'd0,  8'h00, 64'h0000_0000_0000_0077};
    vecs[4] = '{1'b1, 64'h0000_0000_0000_0004, 1'b1, 5'd0,  8'h00, 64'h0000_0000_0000_0077};
    vecs[5] = '{1'b0, 64'h0000_0000_0000_0100, 1'b0, 5'd0,  8'h01, 64'h0000_0000_0000_0077};

    reset = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    Imem2proc_response = '0; Imem2proc_data = '0; Imem2proc_tag = '0;
    pl_en = 1'b0; pl_idx = '0; pl_tag = '0; pl_data = '0; model_clr = 1'b1;
    tick(); tick();
    model_clr = 1'b0;
    reset = 1'b1;
    #1;

    check("rst_state",  dbg_state, S_IDLE);
    check("rst_wr_en",  wr_en, 0);
    check("rst_wr_idx", wr_idx, 0);
    check("rst_wr_tag", wr_tag, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_cmd",    proc2Imem_command, C_NONE);
    check("rst_addr",   proc2Imem_addr, 0);

    // table: hit path and fetch_req=0, no miss started
    preload(5'd5,  8'hA5, 64'h5555_5555_5555_5555);
    preload(5'd31, 8'hFF, 64'hFFFF_0000_FFFF_0000);
    preload(5'd0,  8'h00, 64'h0000_0000_0000_0077);
    for (int i = 0; i < 6; i++) begin
      fetch_req = vecs[i].req;
      fetch_addr = vecs[i].addr;
      #1;
      check($sformatf("vec%0d_valid", i), fetch_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_idx", i),   rd_idx,      vecs[i].exp_idx);
      check($sformatf("vec%0d_tag", i),   rd_tag,      vecs[i].exp_tag);
      check($sformatf("vec%0d_data", i),  fetch_data,  vecs[i].exp_data);
      tick();
      check($sformatf("vec%0d_cmd", i),   proc2Imem_command, C_NONE);
      check($sformatf("vec%0d_state", i), dbg_state, S_IDLE);
    end
    fetch_req = 1'b0;
    tick();

    // cold miss 0x108: REQ at 1-2, response at 2, tag at 6, fill at 7, hit at 8
    fetch_req = 1'b1; fetch_addr = 64'h108;
    #1;
    check("cold_miss_valid0", fetch_valid, 0);
    w0 = wr_cnt;
    tick();
    check("cold_cmd1",  proc2Imem_command, C_LOAD);
    check("cold_addr1", proc2Imem_addr, 64'h108);
    tick();
    check("cold_cmd2", proc2Imem_command, C_LOAD);
    Imem2proc_response = 4'd3;
    tick();
    Imem2proc_response = 4'd0;
    check("cold_wait_state", dbg_state, S_WAIT);
    check("cold_wait_cmd",   proc2Imem_command, C_NONE);
    tick(); tick(); tick();
    Imem2proc_tag = 4'd3; Imem2proc_data = 64'hDEAD_BEEF;
    check("cold_wr_before", wr_en, 0);
    tick();
    Imem2proc_tag = 4'd0; Imem2proc_data = 64'h0;
    check("cold_wr_en",   wr_en, 1);
    check("cold_wr_idx",  wr_idx, 1);
    check("cold_wr_tag",  wr_tag, 8'h01);
    check("cold_wr_data", wr_data, 64'hDEAD_BEEF);
    check("cold_valid7",  fetch_valid, 0);
    tick();
    check("cold_wr_off",  wr_en, 0);
    check("cold_valid8",  fetch_valid, 1);
    check("cold_data8",   fetch_data, 64'hDEAD_BEEF);
    check("cold_fills",   wr_cnt - w0, 1);

    // hit on same line, no LOAD
    fetch_addr = 64'h10C;
    #1;
    check("hit_valid", fetch_valid, 1);
    check("hit_data",  fetch_data, 64'hDEAD_BEEF);
    l0 = load_cnt;
    tick(); tick();
    check("hit_no_load", load_cnt - l0, 0);
    check("hit_state",   dbg_state, S_IDLE);

    // busy memory: response 0 for three REQ cycles, then 5
    fetch_addr = 64'h414;
    l0 = load_cnt;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("busy_cmd%0d", i),  proc2Imem_command, C_LOAD);
      check($sformatf("busy_addr%0d", i), proc2Imem_addr, 64'h410);
      if (i == 3) Imem2proc_response = 4'd5;
      tick();
    end
    Imem2proc_response = 4'd0;
    check("busy_load_cycles", load_cnt - l0, 4);
    check("busy_wait_state",  dbg_state, S_WAIT);
    check("busy_wait_cmd",    proc2Imem_command, C_NONE);

    // hit served while a miss is outstanding
    fetch_addr = 64'h108;
    #1;
    check("miss_hit_valid", fetch_valid, 1);
    check("miss_hit_data",  fetch_data, 64'hDEAD_BEEF);
    fetch_addr = 64'h414;

    // wrong tag ignored, right tag fills once
    w0 = wr_cnt;
    Imem2proc_tag = 4'd2; Imem2proc_data = 64'hBAD0_BAD0;
    tick();
    Imem2proc_tag = 4'd0;
    check("wrong_tag_wr",    wr_en, 0);
    check("wrong_tag_state", dbg_state, S_WAIT);
    tick();
    Imem2proc_tag = 4'd5; Imem2proc_data = 64'h1234;
    tick();
    Imem2proc_tag = 4'd0; Imem2proc_data = 64'h0;
    check("right_tag_wr",   wr_en, 1);
    check("right_tag_idx",  wr_idx, 2);
    check("right_tag_tag",  wr_tag, 8'h04);
    check("right_tag_data", wr_data, 64'h1234);
    tick();
    check("right_tag_fills", wr_cnt - w0, 1);
    check("right_tag_hit",   fetch_valid, 1);
    fetch_req = 1'b0;
    tick();

    // address change during WAIT keeps the original line
    fetch_req = 1'b1; fetch_addr = 64'h200;
    tick();
    Imem2proc_response = 4'd1;
    tick();
    Imem2proc_response = 4'd0;
    fetch_addr = 64'h300;
    tick();
    check("chg_state", dbg_state, S_WAIT);
    Imem2proc_tag = 4'd1; Imem2proc_data = 64'hAAAA;
    tick();
    Imem2proc_tag = 4'd0;
    check("chg_wr_en",  wr_en, 1);
    check("chg_wr_idx", wr_idx, 0);
    check("chg_wr_tag", wr_tag, 8'h02);
    tick();
    check("chg_idle_miss", fetch_valid, 0);
    tick();
    check("chg_new_cmd",  proc2Imem_command, C_LOAD);
    check("chg_new_addr", proc2Imem_addr, 64'h300);
    Imem2proc_response = 4'd7;
    tick();
    Imem2proc_response = 4'd0;
    fetch_req = 1'b0;
    check("rw_wait_state", dbg_state, S_WAIT);

    // asynchronous reset in WAIT, then stale tag returns
    reset = 1'b0;
    #1;
    check("rw_async_state", dbg_state, S_IDLE);
    check("rw_async_cmd",   proc2Imem_command, C_NONE);
    tick();
    reset = 1'b1;
    w0 = wr_cnt;
    Imem2proc_tag = 4'd7; Imem2proc_data = 64'hCAFE;
    tick();
    Imem2proc_tag = 4'd0;
    check("rw_stale_wr",  wr_en, 0);
    check("rw_stale_cmd", proc2Imem_command, C_NONE);
    tick();
    check("rw_no_fill",   wr_cnt - w0, 0);
    check("rw_state",     dbg_state, S_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
